// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, instruction classes and field helpers shared by the decode stage
package decode_pkg;

  localparam int OPC_BITS = 6;

  localparam logic [OPC_BITS-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_BITS-1:0] OPC_ADDI  = 6'b000001;
  localparam logic [OPC_BITS-1:0] OPC_J     = 6'b000010;
  localparam logic [OPC_BITS-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_BITS-1:0] OPC_LW    = 6'b001000;
  localparam logic [OPC_BITS-1:0] OPC_SW    = 6'b001001;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_ILL = 2'd3
  } instr_class_e;

  function automatic int imm_width(input int xlen, input int opc_w, input int ra_w);
    return xlen - opc_w - 2 * ra_w;
  endfunction

  // Opcode arrives zero-extended so wider opcode fields with stray upper bits fall to illegal.
  function automatic instr_class_e classify(input logic [31:0] opc);
    instr_class_e c;
    case (opc)
      32'(OPC_RTYPE):                                    c = CLS_R;
      32'(OPC_ADDI), 32'(OPC_LW), 32'(OPC_SW), 32'(OPC_BEQ): c = CLS_I;
      32'(OPC_J):                                        c = CLS_J;
      default:                                           c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - DEPTH-entry buffer of {instr, pc} words with flush
module decode_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - buffered instruction decode with load-use bubble insertion
module decode_stage
  import decode_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int OPC_W = 6,
  parameter  int RA_W  = 5,
  parameter  int DEPTH = 2,
  localparam int IMM_W = imm_width(XLEN, OPC_W, RA_W),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] out_opcode,
  output logic [RA_W-1:0]  out_rs,
  output logic [RA_W-1:0]  out_rt,
  output logic [RA_W-1:0]  out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [1:0]       out_class,
  output logic             out_bubble
);

  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     count;
  logic              empty, push, pop, hazard;

  logic [XLEN-1:0]   head_instr, head_pc, imm_ext;
  logic [OPC_W-1:0]  opcode;
  logic [RA_W-1:0]   rs, rt;
  logic [IMM_W-1:0]  imm;
  instr_class_e      cls;
  logic              is_lw, reads_rt;

  logic              load_pend_q, load_pend_d;
  logic [RA_W-1:0]   load_rt_q, load_rt_d;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  decode_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_instr, in_pc}),
    .rdata (head),
    .count (count)
  );

  assign head_instr = head[2*XLEN-1:XLEN];
  assign head_pc    = head[XLEN-1:0];
  assign opcode     = head_instr[XLEN-1 -: OPC_W];
  assign rs         = head_instr[XLEN-OPC_W-1 -: RA_W];
  assign rt         = head_instr[XLEN-OPC_W-RA_W-1 -: RA_W];
  assign imm        = head_instr[IMM_W-1:0];
  assign cls        = classify(32'(opcode));
  assign is_lw      = (opcode == OPC_W'(OPC_LW));
  assign reads_rt   = (cls == CLS_R) || (opcode == OPC_W'(OPC_SW)) || (opcode == OPC_W'(OPC_BEQ));
  assign imm_ext    = (cls == CLS_J) ? XLEN'(head_instr[XLEN-OPC_W-1:0])
                                     : {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

  // r0 never carries a loaded value, so a pending load to r0 cannot stall.
  assign hazard = !empty && load_pend_q && (load_rt_q != '0) &&
                  ((rs == load_rt_q) || ((rt == load_rt_q) && reads_rt));

  assign out_valid  = !empty && !hazard;
  assign out_bubble = hazard;

  always_comb begin
    out_opcode = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_rd     = '0;
    out_imm    = '0;
    out_pc     = '0;
    out_class  = '0;
    if (!empty) begin
      out_opcode = opcode;
      out_rs     = rs;
      out_rt     = rt;
      out_rd     = imm[IMM_W-1 -: RA_W];
      out_imm    = imm_ext;
      out_pc     = head_pc;
      out_class  = cls;
    end
  end

  // A bubble lasts one cycle: the stalled head is released by dropping load_pend.
  always_comb begin
    load_pend_d = load_pend_q;
    load_rt_d   = load_rt_q;
    if (flush) begin
      load_pend_d = 1'b0;
    end else if (pop) begin
      load_pend_d = is_lw;
      if (is_lw) load_rt_d = rt;
    end else if (hazard) begin
      load_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_pend_q <= 1'b0;
      load_rt_q   <= '0;
    end else begin
      load_pend_q <= load_pend_d;
      load_rt_q   <= load_rt_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against a queue-based reference model
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_imm, out_pc;
  logic [1:0]  out_class;
  logic        out_bubble;

  decode_stage #(.XLEN(32), .OPC_W(6), .RA_W(5), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_pc     (out_pc),
    .out_class  (out_class),
    .out_bubble (out_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  int          n_bubbles = 0;
  bit          lp = 1'b0;
  int unsigned lrt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned f_opc(input logic [31:0] i); return (i >> 26) & 32'h3F; endfunction
  function automatic int unsigned f_rs(input logic [31:0] i);  return (i >> 21) & 32'h1F; endfunction
  function automatic int unsigned f_rt(input logic [31:0] i);  return (i >> 16) & 32'h1F; endfunction
  function automatic int unsigned f_rd(input logic [31:0] i);  return (i >> 11) & 32'h1F; endfunction

  function automatic int unsigned f_class(input logic [31:0] i);
    case (f_opc(i))
      0:          return 0;
      1, 4, 8, 9: return 1;
      2:          return 2;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] i);
    logic [31:0] lo;
    if (f_opc(i) == 2) return i & 32'h03FF_FFFF;
    lo = i & 32'h0000_FFFF;
    return (lo >= 32'h8000) ? (lo | 32'hFFFF_0000) : lo;
  endfunction

  // Reference model: inputs are stable across the negedge, so this cycle's edge outcome is decided here.
  always @(negedge clk) begin
    int          n;
    bit          haz, exp_valid;
    ent_t        h;
    int unsigned opc, rs, rt;
    if (rst) begin
      exp_q.delete();
      lp = 1'b0;
    end else begin
      n   = exp_q.size();
      haz = 1'b0;
      opc = 0; rs = 0; rt = 0;
      if (n > 0) begin
        h   = exp_q[0];
        opc = f_opc(h.instr);
        rs  = f_rs(h.instr);
        rt  = f_rt(h.instr);
        haz = lp && (lrt != 0) && (rs == lrt || (rt == lrt && (opc == 0 || opc == 9 || opc == 4)));
      end
      exp_valid = (n > 0) && !haz;
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_bubble", 32'(out_bubble), 32'(haz));
      if (out_bubble) n_bubbles++;
      if (n == 0) begin
        chk("idle_data", {out_opcode, out_rs, out_rt, out_rd, out_class, 9'd0}, 32'd0);
        chk("idle_imm", out_imm, 32'd0);
        chk("idle_pc", out_pc, 32'd0);
      end else begin
        chk("opcode", 32'(out_opcode), opc);
        chk("rs", 32'(out_rs), rs);
        chk("rt", 32'(out_rt), rt);
        chk("rd", 32'(out_rd), f_rd(h.instr));
        chk("class", 32'(out_class), f_class(h.instr));
        chk("imm", out_imm, f_imm(h.instr));
        chk("pc", out_pc, h.pc);
      end
      if (flush) begin
        exp_q.delete();
        lp = 1'b0;
      end else begin
        if (exp_valid && out_ready) begin
          lp = (opc == 8);
          if (opc == 8) lrt = rt;
          void'(exp_q.pop_front());
          n_pops++;
        end else if (haz) begin
          lp = 1'b0;
        end
        if (in_valid && n < DEPTH) exp_q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
  end

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    bit acc = 1'b0;
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(posedge clk);
      acc = in_ready;
    end
    #1 in_valid = 1'b0;
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int base_b, base_p;
  bit seen;

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bubble", 32'(out_bubble), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_imm", out_imm, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADDI with all-ones immediate sign-extends to all ones
    out_ready = 1'b1;
    push(32'h05EF_FFFF, 32'h0000_1000);
    @(negedge clk);
    chk("addi_class", 32'(out_class), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_pc", out_pc, 32'h0000_1000);
    idle(2);

    // LW r6 then ADDI reading r6: exactly one bubble, then ADDI delivered
    base_b = n_bubbles; base_p = n_pops;
    push(32'h2106_0000, 32'h0000_2000);
    push(32'h04C7_0004, 32'h0000_2004);
    idle(4);
    chk("loaduse_bubbles", 32'(n_bubbles - base_b), 32'd1);
    chk("loaduse_pops", 32'(n_pops - base_p), 32'd2);

    // LW to r0 never stalls
    base_b = n_bubbles;
    push(32'h2100_0000, 32'h0000_3000);
    push(32'h0400_0001, 32'h0000_3004);
    idle(4);
    chk("r0_bubbles", 32'(n_bubbles - base_b), 32'd0);

    // Back-pressure: two fill the buffer, third waits, order kept on release
    out_ready = 1'b0;
    base_p = n_pops;
    push(32'h0421_0011, 32'h0000_4000);
    push(32'h0442_0022, 32'h0000_4004);
    in_instr = 32'h0463_0033; in_pc = 32'h0000_4008; in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      seen = in_ready;
    end
    #1 in_valid = 1'b0;
    chk("third_accepted", 32'(seen), 32'd1);
    idle(4);
    chk("bp_pops", 32'(n_pops - base_p), 32'd3);

    // Flush with two buffered and a same-cycle push
    out_ready = 1'b0;
    push(32'h0484_0044, 32'h0000_5000);
    push(32'h04A5_0055, 32'h0000_5004);
    in_instr = 32'h04C6_0066; in_pc = 32'h0000_5008; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    base_p = n_pops;
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_pops", 32'(n_pops - base_p), 32'd0);

    // Illegal opcode is still delivered as class 3
    push(32'hFC00_1234, 32'h0000_6000);
    @(negedge clk);
    chk("illegal_class", 32'(out_class), 32'd3);
    chk("illegal_valid", 32'(out_valid), 32'd1);
    idle(2);

    // Reset in the middle of a bubble clears outputs at once
    push(32'h2106_0000, 32'h0000_7000);
    push(32'h04C7_0004, 32'h0000_7004);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = out_bubble;
    end
    chk("bubble_reached", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_out_bubble", 32'(out_bubble), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_out_pc", out_pc, 32'd0);
    chk("rstmid_out_opcode", 32'(out_opcode), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomised traffic with a small register set to provoke hazards
    for (int c = 0; c < 600; c++) begin
      int unsigned opcs[8] = '{0, 1, 8, 9, 4, 2, 63, 8};
      logic [5:0]  o;
      o         = 6'(opcs[$urandom_range(0, 7)]);
      in_instr  = {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(10);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction, PC and immediate width.
REQ-002 SHALL have parameter OPC_W, default 6, meaning opcode field width (instr[XLEN-1 -: OPC_W]).
REQ-003 SHALL have parameter RA_W, default 5, meaning register-address width; IMM_W = XLEN-OPC_W-2*RA_W (default 16).
REQ-004 SHALL have parameter DEPTH, default 2, meaning input buffer entries; power of two, >=2.
REQ-005 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have in_valid/in_ready  input/output  1/1  fetch-side handshake; in_instr  input  XLEN; in_pc  input  XLEN.
REQ-008 SHALL have flush  input  1  discards all buffered instructions and hazard state.
REQ-009 SHALL have out_valid/out_ready  output/input  1/1  execute-side handshake.
REQ-010 SHALL have out_opcode OPC_W, out_rs RA_W, out_rt RA_W, out_rd RA_W (imm[IMM_W-1 -: RA_W]), out_imm XLEN (sign-extended), out_pc XLEN, out_class 2, out_bubble 1, all outputs.

Function
REQ-011 SHALL buffer {instr, pc} in a DEPTH-entry FIFO; push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-012 SHALL drive in_ready = (count < DEPTH); a push into a full buffer SHALL NOT occur even when a pop happens in the same cycle.
REQ-013 SHALL give 1-cycle latency: an instruction pushed at edge N is presented at the outputs after edge N when the buffer was empty.
REQ-014 SHALL decode the FIFO head combinationally; outputs SHALL be held stable while out_valid && !out_ready.
REQ-015 SHALL classify opcodes: 000000 R-type (class 0); 000001 ADDI, 001000 LW, 001001 SW, 000100 BEQ (class 1); 000010 J (class 2); all others illegal (class 3, still delivered).
REQ-016 SHALL sign-extend imm[IMM_W-1:0] to XLEN for classes 0, 1 and 3; for J, out_imm = zero-extended low (XLEN-OPC_W) bits.
REQ-017 SHALL record a load when an LW pops: load_pend=1, load_rt=out_rt.
REQ-018 SHALL detect a load-use hazard when load_pend, load_rt != 0 and head rs == load_rt, or head rt == load_rt with head class 0 or opcode SW/BEQ.
REQ-019 SHALL on hazard force out_valid=0 and out_bubble=1 for exactly one cycle, then clear load_pend; the head is not popped during the bubble.
REQ-020 SHALL clear load_pend on the first pop of a non-LW instruction with no hazard; a back-to-back LW replaces load_rt.
REQ-021 SHALL drive out_valid = !empty && !hazard; out_bubble SHALL be 0 whenever the buffer is empty.
REQ-022 SHALL on flush empty the FIFO, clear load_pend and drop any same-cycle push; out_valid=0 in the following cycle.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-024 SHALL on rst immediately clear count, pointers and load_pend, giving out_valid=0, out_bubble=0, in_ready=1.
REQ-025 SHALL drive every data output to zero while the buffer is empty, including after reset.
REQ-026 SHALL abandon any pending bubble when reset is asserted mid-operation, with no pop.

Structure
REQ-027 SHALL take opcode constants, class encodings and field-extraction widths from a shared package decode_pkg.
REQ-028 SHALL instantiate one sub-module, decode_fifo (parametrised XLEN*2 wide, DEPTH deep); the decode and hazard logic live in decode_stage.

Verification
REQ-029 SHALL cover: push ADDI 0x05EF_FFFF (rs=15, rt=15, imm=0xFFFF), out_ready=1 -> next cycle out_class=1, out_imm=0xFFFF_FFFF, out_pc matches.
REQ-030 SHALL cover: LW 0x2106_0000 (rt=6) then ADDI 0x04C7_0004 (rs=6) -> one cycle out_valid=0, out_bubble=1, then the ADDI is delivered.
REQ-031 SHALL cover: LW with rt=0 followed by a consumer of r0 -> no bubble.
REQ-032 SHALL cover: out_ready=0, three pushes -> in_ready=0 after two; outputs stable; release -> order preserved.
REQ-033 SHALL cover: flush with two entries buffered and in_valid=1 -> next cycle out_valid=0, count=0, pushed instruction absent.
REQ-034 SHALL cover: opcode 111111 -> out_class=3, delivered; rst asserted during a bubble -> outputs zero immediately.
